// File: rtl/lut_layer_pkg.sv
// Shared types and width helpers for the time-multiplexed LogicNets layer evaluator.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_idx_w(input int in_width);
    return (in_width > 1) ? $clog2(in_width) : 1;
  endfunction

  function automatic int calc_nid_w(input int neurons);
    return (neurons > 1) ? $clog2(neurons) : 1;
  endfunction

endpackage

// File: rtl/lut_tt_mem.sv
// Shared truth-table store: one bit per entry, synchronous write, asynchronous read,
// shaped so synthesis maps it onto distributed LUT RAM.
module lut_tt_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic          i_wbit,
  input  logic [AW-1:0] i_raddr,
  output logic          o_rbit
);

  logic r_mem [0:(1<<AW)-1];

  // Write port; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wbit;
    end
  end

  assign o_rbit = r_mem[i_raddr];

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates one LogicNets layer by walking every neuron through a shared truth-table
// memory with a two-stage gather/lookup pipeline, then presents the packed result.
module lut_layer_scheduler
  import lut_layer_pkg::*;
#(
  parameter int IN_WIDTH = 64,
  parameter int NEURONS  = 16,
  parameter int FANIN    = 8,
  parameter int IDX_W    = calc_idx_w(IN_WIDTH),
  parameter int NID_W    = calc_nid_w(NEURONS),
  localparam int SLOT_W  = (FANIN > 1) ? $clog2(FANIN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                cfg_ready,
  input  logic                cfg_tt_we,
  input  logic                cfg_conn_we,
  input  logic [NID_W-1:0]    cfg_neuron,
  input  logic [FANIN-1:0]    cfg_tt_addr,
  input  logic                cfg_tt_bit,
  input  logic [SLOT_W-1:0]   cfg_conn_slot,
  input  logic [IDX_W-1:0]    cfg_conn_idx,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NEURONS-1:0]  out_data,
  output logic                busy
);

  state_t               r_state, w_state_nxt;
  logic [IN_WIDTH-1:0]  r_in;
  logic [IDX_W-1:0]     r_conn [NEURONS][FANIN];
  logic [NID_W:0]       r_cnt;
  logic [FANIN-1:0]     r_addr, w_addr;
  logic [NID_W-1:0]     r_c;
  logic                 r_b_valid;
  logic [NEURONS-1:0]   r_result, w_result_nxt;
  logic                 r_out_valid;
  logic [NEURONS-1:0]   r_out_data;
  logic                 w_tt_rbit, w_cfg_en, w_idx_ok, w_accept, w_stage_a, w_last, w_release;

  assign w_cfg_en  = (r_state == IDLE);
  assign w_accept  = w_cfg_en & in_valid;
  assign w_stage_a = (r_state == RUN) && (r_cnt < (NID_W+1)'(NEURONS));
  assign w_last    = (r_state == RUN) && r_b_valid && (r_c == NID_W'(NEURONS - 1));
  assign w_release = (r_state == DONE) && out_ready;

  // An index that fits the port but not the vector must not reach the table
  generate
    if (IN_WIDTH >= (1 << IDX_W)) begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
      assign w_idx_ok = (cfg_conn_idx < IDX_W'(IN_WIDTH));
    end
  endgenerate

  lut_tt_mem #(.AW(NID_W + FANIN)) u_tt_mem (
    .clk     (clk),
    .i_we    (cfg_tt_we & w_cfg_en),
    .i_waddr ({cfg_neuron, cfg_tt_addr}),
    .i_wbit  (cfg_tt_bit),
    .i_raddr ({r_c, r_addr}),
    .o_rbit  (w_tt_rbit)
  );

  // Stage A gather: slot k of the current neuron drives address bit k
  always_comb begin
    w_addr = '0;
    for (int k = 0; k < FANIN; k++) begin
      w_addr[k] = r_in[r_conn[r_cnt[NID_W-1:0]][k]];
    end
  end

  // Stage B lookup merged into the result vector
  always_comb begin
    w_result_nxt = r_result;
    if (r_b_valid) begin
      w_result_nxt[r_c] = w_tt_rbit;
    end else begin
      w_result_nxt = r_result;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = in_valid ? RUN : IDLE;
      RUN:     w_state_nxt = w_last ? DONE : RUN;
      DONE:    w_state_nxt = out_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Connectivity table, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NEURONS; n++) begin
        for (int k = 0; k < FANIN; k++) begin
          r_conn[n][k] <= '0;
        end
      end
    end else if (cfg_conn_we && w_cfg_en && w_idx_ok) begin
      r_conn[cfg_neuron][cfg_conn_slot] <= cfg_conn_idx;
    end
  end

  // Pipeline datapath: input capture, neuron counter, stage registers, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in      <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_c       <= '0;
      r_b_valid <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_in      <= in_data;
      r_cnt     <= '0;
      r_b_valid <= 1'b0;
      r_result  <= '0;
    end else begin
      r_b_valid <= w_stage_a;
      r_result  <= w_result_nxt;
      if (w_stage_a) begin
        r_addr <= w_addr;
        r_c    <= r_cnt[NID_W-1:0];
        r_cnt  <= r_cnt + (NID_W+1)'(1);
      end
    end
  end

  // Output register: loaded with the final bit already merged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result_nxt;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign in_ready  = (r_state == IDLE);
  assign cfg_ready = (r_state == IDLE);
  assign busy      = (r_state == RUN);

endmodule
